uart_lite: RTL and testbench

Memory-mapped UART peripheral on the SoC's 12-bit CPU bus, a sibling slave to the SPI, timer and PWM blocks. The top-level address decoder qualifies `cs`. The block buffers CPU bytes in a 4-deep TX FIFO and serialises them 8N1 on `txd`. It deserialises `rxd` into a 4-deep RX FIFO. The CPU polls a status register and can also use the `irq` level.

---
 rtl/uart_lite.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_lite.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite.sv
// Memory-mapped 8N1 UART: 4-deep TX/RX byte FIFOs, programmable bit divisor,
// polled status register and a level irq while received data is waiting.
module uart_lite_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

module uart_lite #(
   parameter logic [7:0] DIV_RESET  = 8'd15,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       cs,
   input  logic       rdwr,
   input  logic [1:0] addr,
   input  logic [7:0] datain,
   output logic [7:0] dataout,
   output logic       txd,
   input  logic       rxd,
   output logic       irq
);
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   logic       cs_q, strobe, wr_stb, rd_stb, status_rd;
   logic [7:0] divisor;
   logic       rx_overrun, frame_err;

   // CPU access: one strobe per cs high period
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) cs_q <= 1'b0;
      else     cs_q <= cs;
   end

   assign strobe    = cs & ~cs_q;
   assign wr_stb    = strobe & rdwr;
   assign rd_stb    = strobe & ~rdwr;
   assign status_rd = rd_stb & (addr == 2'd1);

   always_ff @(posedge clkin or posedge rst) begin
      if (rst)                          divisor <= DIV_RESET;
      else if (wr_stb && addr == 2'd2)  divisor <= datain;
   end

   // ---------------- TX ----------------
   tx_state_t  tx_state, tx_next;
   logic [7:0] tx_head, tx_div, tx_cnt, tx_sh;
   logic [2:0] tx_bit;
   logic       tx_empty, tx_full, tx_pop, tx_bit_end, tx_idle;

   uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clkin(clkin), .rst(rst),
      .push(wr_stb && addr == 2'd0), .pop(tx_pop), .din(datain),
      .dout(tx_head), .empty(tx_empty), .full(tx_full)
   );

   assign tx_bit_end = (tx_cnt == tx_div);
   assign tx_idle    = tx_empty & (tx_state == T_IDLE);

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) tx_state <= T_IDLE;
      else     tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         T_IDLE:  if (!tx_empty) begin
                     tx_next = T_START;
                     tx_pop  = 1'b1;
                  end
         T_START: if (tx_bit_end) tx_next = T_DATA;
         T_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = T_STOP;
         T_STOP:  if (tx_bit_end) begin
                     if (!tx_empty) begin
                        tx_next = T_START;
                        tx_pop  = 1'b1;
                     end else begin
                        tx_next = T_IDLE;
                     end
                  end
         default: tx_next = T_IDLE;
      endcase
   end

   // txd is the registered line value so it cannot glitch between states
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         tx_div <= '0;
         tx_cnt <= '0;
         tx_sh  <= '0;
         tx_bit <= '0;
         txd    <= 1'b1;
      end else begin
         if (tx_pop) begin
            tx_sh  <= tx_head;
            tx_div <= divisor;
            tx_cnt <= '0;
            tx_bit <= '0;
         end else if (tx_state != T_IDLE) begin
            if (tx_bit_end) begin
               tx_cnt <= '0;
               if (tx_state == T_DATA) begin
                  tx_sh  <= tx_sh >> 1;
                  tx_bit <= tx_bit + 3'd1;
               end
            end else begin
               tx_cnt <= tx_cnt + 8'd1;
            end
         end
         txd <= (tx_state == T_START) ? 1'b0 :
                (tx_state == T_DATA)  ? tx_sh[0] : 1'b1;
      end
   end

   // ---------------- RX ----------------
   rx_state_t  rx_state, rx_next;
   logic       rx_s1, rx_s2, rx_s3, rx_fall;
   logic [7:0] rx_div, rx_cnt, rx_sh, rx_head, rx_half;
   logic [8:0] rx_half_w;
   logic [2:0] rx_bit;
   logic       rx_empty, rx_full, rx_done, rx_bit_end, rx_push, rx_pop;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rxd;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign rx_fall    = rx_s3 & ~rx_s2;
   assign rx_half_w  = ({1'b0, rx_div} + 9'd1) >> 1;
   assign rx_half    = rx_half_w[7:0];
   assign rx_bit_end = (rx_cnt == rx_div);
   assign rx_push    = rx_done & rx_s2 & ~rx_full;
   assign rx_pop     = rd_stb & (addr == 2'd0) & ~rx_empty;

   uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clkin(clkin), .rst(rst),
      .push(rx_push), .pop(rx_pop), .din(rx_sh),
      .dout(rx_head), .empty(rx_empty), .full(rx_full)
   );

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) rx_state <= R_IDLE;
      else     rx_state <= rx_next;
   end

   // div=0 puts the start sample on the falling-edge cycle itself, so skip START
   always_comb begin
      rx_next = rx_state;
      rx_done = 1'b0;
      case (rx_state)
         R_IDLE:  if (rx_fall) rx_next = (divisor == 8'd0) ? R_DATA : R_START;
         R_START: if (rx_cnt == rx_half) rx_next = rx_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = R_STOP;
         R_STOP:  if (rx_bit_end) begin
                     rx_next = R_IDLE;
                     rx_done = 1'b1;
                  end
         default: rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         rx_div <= '0;
         rx_cnt <= '0;
         rx_sh  <= '0;
         rx_bit <= '0;
      end else begin
         case (rx_state)
            R_IDLE: begin
               rx_div <= divisor;
               rx_cnt <= (divisor == 8'd0) ? 8'd0 : 8'd1;
               rx_bit <= '0;
            end
            R_START: rx_cnt <= (rx_cnt == rx_half) ? 8'd0 : rx_cnt + 8'd1;
            R_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s2, rx_sh[7:1]};
                  rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 8'd1;
               end
            end
            default: rx_cnt <= rx_cnt + 8'd1;
         endcase
      end
   end

   // a flag event on the clearing edge keeps the flag set
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (rx_done && rx_s2 && rx_full) rx_overrun <= 1'b1;
         else if (status_rd)              rx_overrun <= 1'b0;
         if (rx_done && !rx_s2)           frame_err  <= 1'b1;
         else if (status_rd)              frame_err  <= 1'b0;
      end
   end

   assign irq = ~rx_empty;

   always_comb begin
      dataout = 8'h00;
      if (cs) begin
         case (addr)
            2'd0:    dataout = rx_empty ? 8'h00 : rx_head;
            2'd1:    dataout = {3'b000, frame_err, rx_overrun, ~rx_empty, tx_idle, tx_full};
            2'd2:    dataout = divisor;
            default: dataout = 8'h00;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_lite.sv
// Scoreboard bench for uart_lite: TX frames captured by a line monitor,
// RX frames injected on rxd, both compared against queued expectations.
module tb_uart_lite;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0, rdwr = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] datain = 8'h00;
   logic [7:0] dataout;
   logic       txd, rxd, irq;
   logic       rxd_drv = 1'b1;
   logic       loop = 1'b0;

   int   checks = 0, failures = 0;
   int   tb_div = 15;
   bit   mon_en = 1'b1;

   logic [8:0] tx_got [$];
   logic [7:0] tx_exp [$];
   logic [7:0] rx_exp [$];

   assign rxd = loop ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_lite dut (
      .clkin(clk), .rst(rst), .cs(cs), .rdwr(rdwr), .addr(addr),
      .datain(datain), .dataout(dataout), .txd(txd), .rxd(rxd), .irq(irq)
   );

   // TX line monitor: samples each bit mid-period, queues {stop, data}
   always begin : tx_mon
      int         d;
      logic [7:0] b;
      logic       s;
      @(negedge clk);
      if (mon_en && !rst && txd === 1'b0) begin
         d = tb_div;
         repeat ((d + 1) / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (d + 1) @(negedge clk);
            b[i] = txd;
         end
         repeat (d + 1) @(negedge clk);
         s = txd;
         tx_got.push_back({s, b});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; rdwr = 1'b1; addr = a; datain = d;
      @(negedge clk);
      cs = 1'b0; rdwr = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
      cs = 1'b1; rdwr = 1'b0; addr = a;
      #1 d = dataout;
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_div(input logic [7:0] d);
      cpu_write(2'd2, d);
      tb_div = int'(d);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_drv = f[i];
         repeat (d + 1) @(negedge clk);
      end
      rxd_drv = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (txd !== 1'b1 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: txd=%b irq=%b, required txd=1 irq=0", txd, irq);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dataout !== 8'h00) begin
         failures++;
         $display("FAIL reset_dataout_cs_low: got %h required 00", dataout);
      end
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02) begin
         failures++;
         $display("FAIL reset_status: got %h required 02", v);
      end
      cpu_read(2'd2, v);
      checks++;
      if (v !== 8'h0F) begin
         failures++;
         $display("FAIL reset_divisor: got %h required 0f", v);
      end
   endtask

   task automatic test_tx_single();
      logic [7:0]  v, e;
      logic [9:0]  frame;
      logic [39:0] cap, expv;
      set_div(8'd3);
      tx_exp.push_back(8'hA5);
      cpu_write(2'd0, 8'hA5);
      // cpu_write ends one clock after the strobe edge
      checks++;
      if (txd !== 1'b1) begin
         failures++;
         $display("FAIL tx_latency_early: txd=%b one clock after strobe, required 1", txd);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cap[k] = txd;
      end
      e = tx_exp.pop_front();
      frame = {1'b1, e, 1'b0};
      for (int k = 0; k < 40; k++) expv[k] = frame[k / 4];
      checks++;
      if (cap !== expv) begin
         failures++;
         $display("FAIL tx_waveform: got %h required %h", cap, expv);
      end
      checks++;
      if (tx_got.size() == 0) begin
         failures++;
         $display("FAIL tx_single_mon: no frame seen, required %h", e);
      end else begin
         v = tx_got[0][7:0];
         if (tx_got.pop_front() !== {1'b1, e}) begin
            failures++;
            $display("FAIL tx_single_mon: got %h required %h", v, e);
         end
      end
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02) begin
         failures++;
         $display("FAIL tx_idle_after_frame: status %h required 02", v);
      end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] b [6];
      logic [7:0] v, e;
      logic [8:0] g;
      b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 5; i++) begin
         tx_exp.push_back(b[i]);
         cpu_write(2'd0, b[i]);
      end
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h01) begin
         failures++;
         $display("FAIL tx_full_status: got %h required 01", v);
      end
      cpu_write(2'd0, b[5]);
      for (int i = 0; i < 400 && tx_got.size() < 5; i++) @(negedge clk);
      checks++;
      if (tx_got.size() != 5) begin
         failures++;
         $display("FAIL tx_overflow_count: got %0d frames required 5", tx_got.size());
      end
      while (tx_got.size() > 0 && tx_exp.size() > 0) begin
         g = tx_got.pop_front();
         e = tx_exp.pop_front();
         checks++;
         if (g !== {1'b1, e}) begin
            failures++;
            $display("FAIL tx_overflow_byte: got %h required %h", g, {1'b1, e});
         end
      end
      tx_exp.delete();
      repeat (60) @(negedge clk);
      checks++;
      if (tx_got.size() != 0) begin
         failures++;
         $display("FAIL tx_dropped_byte_sent: got %0d extra frames required 0", tx_got.size());
      end
      tx_got.delete();
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02) begin
         failures++;
         $display("FAIL tx_overflow_idle: status %h required 02", v);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] v;
      logic [8:0] g;
      set_div(8'd7);
      loop = 1'b1;
      tx_exp.push_back(8'h3C);
      rx_exp.push_back(8'h3C);
      cpu_write(2'd0, 8'h3C);
      for (int i = 0; i < 300 && irq !== 1'b1; i++) @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL loop_irq: irq=%b required 1", irq);
      end
      cpu_read(2'd1, v);
      checks++;
      if (v[2] !== 1'b1) begin
         failures++;
         $display("FAIL loop_rx_avail: status %h required bit2=1", v);
      end
      cpu_read(2'd0, v);
      checks++;
      if (v !== rx_exp[0]) begin
         failures++;
         $display("FAIL loop_rx_byte: got %h required %h", v, rx_exp[0]);
      end
      void'(rx_exp.pop_front());
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL loop_irq_clear: irq=%b required 0", irq);
      end
      for (int i = 0; i < 100 && tx_got.size() == 0; i++) @(negedge clk);
      checks++;
      g = (tx_got.size() > 0) ? tx_got.pop_front() : 9'h000;
      if (g !== {1'b1, tx_exp[0]}) begin
         failures++;
         $display("FAIL loop_tx_byte: got %h required %h", g, {1'b1, tx_exp[0]});
      end
      tx_exp.delete();
      repeat (10) @(negedge clk);
      loop = 1'b0;
   endtask

   task automatic test_rx_overrun_frame();
      logic [7:0] b [5];
      logic [7:0] v;
      b = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE7};
      set_div(8'd3);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) rx_exp.push_back(b[i]);
         send_rx(b[i], 1'b1, 3);
      end
      repeat (10) @(negedge clk);
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h0E) begin
         failures++;
         $display("FAIL rx_overrun_set: status %h required 0e", v);
      end
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h06) begin
         failures++;
         $display("FAIL rx_overrun_clear: status %h required 06", v);
      end
      send_rx(8'h66, 1'b0, 3);
      repeat (10) @(negedge clk);
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h16) begin
         failures++;
         $display("FAIL rx_frame_err: status %h required 16", v);
      end
      while (rx_exp.size() > 0) begin
         cpu_read(2'd0, v);
         checks++;
         if (v !== rx_exp[0]) begin
            failures++;
            $display("FAIL rx_fifo_byte: got %h required %h", v, rx_exp[0]);
         end
         void'(rx_exp.pop_front());
      end
      cpu_read(2'd0, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL rx_empty_read: got %h required 00", v);
      end
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02 || irq !== 1'b0) begin
         failures++;
         $display("FAIL rx_drained: status %h irq %b required 02 irq 0", v, irq);
      end
   endtask

   task automatic test_strobe_glitch();
      logic [7:0] v;
      rx_exp.push_back(8'h5A);
      send_rx(8'h5A, 1'b1, 3);
      rx_exp.push_back(8'h96);
      send_rx(8'h96, 1'b1, 3);
      repeat (10) @(negedge clk);
      cs = 1'b1; rdwr = 1'b0; addr = 2'd0;
      #1 v = dataout;
      repeat (5) @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      checks++;
      if (v !== rx_exp[0]) begin
         failures++;
         $display("FAIL strobe_head: got %h required %h", v, rx_exp[0]);
      end
      void'(rx_exp.pop_front());
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h06) begin
         failures++;
         $display("FAIL strobe_single_pop: status %h required 06", v);
      end
      cpu_read(2'd0, v);
      checks++;
      if (v !== rx_exp[0]) begin
         failures++;
         $display("FAIL strobe_second: got %h required %h", v, rx_exp[0]);
      end
      void'(rx_exp.pop_front());
      set_div(8'd15);
      rxd_drv = 1'b0;
      repeat (2) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (200) @(negedge clk);
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02 || irq !== 1'b0) begin
         failures++;
         $display("FAIL rx_glitch: status %h irq %b required 02 irq 0", v, irq);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] v;
      mon_en = 1'b0;
      set_div(8'd3);
      send_rx(8'h77, 1'b1, 3);
      repeat (10) @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_irq: irq=%b required 1", irq);
      end
      set_div(8'd15);
      cpu_write(2'd0, 8'h00);
      for (int i = 0; i < 10 && txd !== 1'b0; i++) @(negedge clk);
      checks++;
      if (txd !== 1'b0) begin
         failures++;
         $display("FAIL pre_reset_start: txd=%b required 0", txd);
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (txd !== 1'b1 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: txd=%b irq=%b required txd=1 irq=0", txd, irq);
      end
      @(negedge clk);
      rst = 1'b0;
      tb_div = 15;
      @(negedge clk);
      cpu_read(2'd1, v);
      checks++;
      if (v !== 8'h02) begin
         failures++;
         $display("FAIL reset_mid_status: got %h required 02", v);
      end
      cpu_read(2'd2, v);
      checks++;
      if (v !== 8'h0F) begin
         failures++;
         $display("FAIL reset_mid_divisor: got %h required 0f", v);
      end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_tx_overflow();
      test_loopback();
      test_rx_overrun_frame();
      test_strobe_glitch();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
